// File: rtl/dmem_pkg.sv
// Shared encodings and the misalignment predicate for the data-memory responder.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Size 2'b11 behaves as a word.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = addr_lo[0];
            default: mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store byte-enable/merge and load shift/extend.
// Sub-word offsets are forced to natural alignment (half: addr[0]=0, word: addr[1:0]=0).
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_sign,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_old_word,
    output logic [31:0] o_merged,
    output logic [3:0]  o_be,
    output logic [31:0] o_rdata
);

    logic [1:0]  w_off;
    logic [31:0] w_rep;
    logic [31:0] w_shifted;

    always_comb begin
        w_off = 2'b00;
        w_rep = i_wdata;
        o_be  = 4'b1111;
        case (i_size)
            SZ_BYTE: begin
                w_off = i_addr_lo;
                w_rep = {4{i_wdata[7:0]}};
                o_be  = 4'b0001 << w_off;
            end
            SZ_HALF: begin
                w_off = {i_addr_lo[1], 1'b0};
                w_rep = {2{i_wdata[15:0]}};
                o_be  = 4'b0011 << w_off;
            end
            default: begin
                w_off = 2'b00;
                w_rep = i_wdata;
                o_be  = 4'b1111;
            end
        endcase
    end

    always_comb begin
        o_merged = i_old_word;
        for (int i = 0; i < 4; i++) begin
            if (o_be[i]) begin
                o_merged[8*i +: 8] = w_rep[8*i +: 8];
            end
        end
    end

    assign w_shifted = i_old_word >> {w_off, 3'b000};

    always_comb begin
        o_rdata = w_shifted;
        case (i_size)
            SZ_BYTE: o_rdata = {{24{i_sign & w_shifted[7]}}, w_shifted[7:0]};
            SZ_HALF: o_rdata = {{16{i_sign & w_shifted[15]}}, w_shifted[15:0]};
            default: o_rdata = w_shifted;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder with pipeline stall and lane handling.
// Optional build macro DMEM_MISALIGN_CHECK_EN: misaligned half/word accesses report rsp_err.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [31:0]       i_req_wdata,
    input  logic [1:0]        i_req_size,
    input  logic              i_req_sign,
    output logic              o_rsp_valid,
    output logic [31:0]       o_rsp_rdata,
    output logic              o_rsp_err,
    output logic              o_stall
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t             r_state;
    state_t             w_state_d;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_we;
    logic [IDX_W+1:0]   r_addr;
    logic [31:0]        r_wdata;
    logic [1:0]         r_size;
    logic               r_sign;
    logic [31:0]        r_rdata;
    logic [31:0]        r_mem [DEPTH_WORDS];

    logic               w_accept;
    logic               w_commit;
    logic               w_blocked;
    logic [IDX_W-1:0]   w_idx;
    logic [31:0]        w_old_word;
    logic [31:0]        w_merged;
    logic [3:0]         w_be;
    logic [31:0]        w_load;
    logic               w_unused_addr;

    // Upper address bits alias; only the word index and byte offset are kept.
    assign w_unused_addr = ^i_req_addr;

    assign w_idx      = r_addr[IDX_W+1:2];
    assign w_old_word = r_mem[w_idx];
    assign w_accept   = (r_state == ST_IDLE) && i_req_valid;
    // Gated by reset so a pending store never lands during reset.
    assign w_commit   = (r_state == ST_BUSY) && (r_cnt == '0) && i_rstn;

`ifdef DMEM_MISALIGN_CHECK_EN
    logic r_err;

    assign w_blocked = is_misaligned(r_size, r_addr[1:0]);
    assign o_rsp_err = r_err && (r_state == ST_RESP);

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_err <= 1'b0;
        end else if (w_commit) begin
            r_err <= w_blocked;
        end
    end
`else
    assign w_blocked = 1'b0;
    assign o_rsp_err = 1'b0;
`endif

    dmem_lane_align u_lane_align (
        .i_addr_lo  (r_addr[1:0]),
        .i_size     (r_size),
        .i_sign     (r_sign),
        .i_wdata    (r_wdata),
        .i_old_word (w_old_word),
        .o_merged   (w_merged),
        .o_be       (w_be),
        .o_rdata    (w_load)
    );

    always_comb begin
        w_state_d   = r_state;
        o_req_ready = 1'b0;
        o_stall     = 1'b0;
        o_rsp_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_req_ready = 1'b1;
                o_stall     = i_req_valid;
                if (i_req_valid) begin
                    w_state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                o_stall = 1'b1;
                if (r_cnt == '0) begin
                    w_state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                o_rsp_valid = 1'b1;
                w_state_d   = ST_IDLE;
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_size  <= SZ_BYTE;
            r_sign  <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_accept) begin
                r_we    <= i_req_we;
                r_addr  <= i_req_addr[IDX_W+1:0];
                r_wdata <= i_req_wdata;
                r_size  <= i_req_size;
                r_sign  <= i_req_sign;
                r_cnt   <= CNT_W'(LATENCY - 1);
            end else if ((r_state == ST_BUSY) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_commit) begin
                r_rdata <= (r_we || w_blocked) ? 32'h0 : w_load;
            end
        end
    end

    // Storage is deliberately not reset; w_merged already holds untouched lanes.
    always_ff @(posedge i_clk) begin
        if (w_commit && r_we && !w_blocked && (w_be != 4'b0000)) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    assign o_rsp_rdata = r_rdata;

endmodule
